// File: rtl/hex_frame_capture.sv
// Receiver for a time-multiplexed {an,d} nibble scan: synchronises, deglitches,
// checks the digit order and reassembles the 32-bit word.
module hex_frame_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned TIMEOUT_W     = 23
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  d,
  input  logic [2:0]  an,
  output logic [31:0] data,
  output logic        data_valid,
  output logic        frame_done,
  output logic        seq_err,
  output logic        stale
);

  localparam int unsigned SMP_W = 7;
  localparam int unsigned RUN_W = 8;

  logic [SMP_W-1:0]     sync1_q, sync2_q, prev_q;
  logic [RUN_W-1:0]     run_q, run_d;
  logic [31:0]          shadow_q, shadow_d;
  logic [31:0]          data_q, data_d;
  logic [7:0]           mask_q, mask_d;
  logic [2:0]           last_an_q, last_an_d;
  logic                 valid_q, valid_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 stale_q, stale_d;
  logic [TIMEOUT_W-1:0] wd_q, wd_d;

  logic       accept_c;
  logic [2:0] acc_an_c;
  logic [3:0] acc_d_c;
  logic [2:0] next_an_c;
  logic [7:0] mask_upd_c;

  assign acc_an_c  = sync2_q[6:4];
  assign acc_d_c   = sync2_q[3:0];
  assign next_an_c = last_an_q + 3'd1;
  assign accept_c  = (sync2_q == prev_q) && (run_q == RUN_W'(STABLE_CYCLES - 1));

  // Next-state logic: stability filter, digit assembly, order check, watchdog.
  always_comb begin
    run_d      = run_q;
    shadow_d   = shadow_q;
    data_d     = data_q;
    mask_d     = mask_q;
    mask_upd_c = mask_q;
    last_an_d  = last_an_q;
    valid_d    = valid_q;
    done_d     = 1'b0;
    err_d      = err_q;
    wd_d       = wd_q;

    if (sync2_q != prev_q) begin
      run_d = RUN_W'(1);
    end else if (run_q != RUN_W'(STABLE_CYCLES)) begin
      run_d = run_q + RUN_W'(1);
    end

    if (accept_c) begin
      shadow_d[{acc_an_c, 2'b00} +: 4] = acc_d_c;
      if (acc_an_c != last_an_q) begin
        if (acc_an_c == next_an_c) begin
          mask_upd_c[acc_an_c] = 1'b1;
        end else begin
          err_d      = 1'b1;
          mask_upd_c = 8'd0;
          mask_upd_c[acc_an_c] = 1'b1;
        end
      end
      last_an_d = acc_an_c;
      mask_d    = mask_upd_c;
      if (acc_an_c == 3'd7 && (&mask_upd_c)) begin
        data_d  = shadow_d;
        done_d  = 1'b1;
        valid_d = 1'b1;
        err_d   = 1'b0;
      end
      // Digit 7 closes the scan attempt whether or not it completed a frame.
      if (acc_an_c == 3'd7 && acc_an_c != last_an_q) begin
        mask_d = 8'd0;
      end
    end

    if (accept_c) begin
      wd_d = '0;
    end else if (!(&wd_q)) begin
      wd_d = wd_q + TIMEOUT_W'(1);
    end
    stale_d = &wd_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      run_q     <= '0;
      shadow_q  <= '0;
      data_q    <= '0;
      mask_q    <= '0;
      last_an_q <= 3'd7;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      stale_q   <= 1'b0;
      wd_q      <= '0;
    end else begin
      sync1_q   <= {an, d};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      run_q     <= run_d;
      shadow_q  <= shadow_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      last_an_q <= last_an_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      wd_q      <= wd_d;
    end
  end

  assign data       = data_q;
  assign data_valid = valid_q;
  assign frame_done = done_q;
  assign seq_err    = err_q;
  assign stale      = stale_q;

endmodule

// File: tb/tb_hex_frame_capture.sv
// Directed self-checking bench for hex_frame_capture (STABLE_CYCLES=4, TIMEOUT_W=6).
module tb_hex_frame_capture;

  logic        clk;
  logic        rst_n;
  logic [3:0]  d_i;
  logic [2:0]  an_i;
  logic [31:0] data;
  logic        data_valid;
  logic        frame_done;
  logic        seq_err;
  logic        stale;

  int n_chk  = 0;
  int n_err  = 0;
  int fd_cnt = 0;
  int fd0;

  hex_frame_capture #(
    .STABLE_CYCLES(4),
    .TIMEOUT_W    (6)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .d         (d_i),
    .an        (an_i),
    .data      (data),
    .data_valid(data_valid),
    .frame_done(frame_done),
    .seq_err   (seq_err),
    .stale     (stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count frame_done pulses, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (rst_n && frame_done) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic put(input logic [2:0] a, input logic [3:0] v, input int n);
    an_i = a;
    d_i  = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [31:0] w, input int first, input int last);
    for (int i = first; i <= last; i++) put(3'(i), w[4*i +: 4], 8);
  endtask

  initial begin
    logic [31:0] w;
    rst_n = 1'b0;
    an_i  = 3'd7;
    d_i   = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 32'h0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_err", 32'(seq_err), 32'd0);
    chk("rst_stale", 32'(stale), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Clean frame with exact latency on digit 7.
    w   = 32'h1234ABCD;
    fd0 = fd_cnt;
    scan(w, 0, 6);
    an_i = 3'd7;
    d_i  = w[31:28];
    repeat (5) @(negedge clk);
    chk("lat_done_early", 32'(frame_done), 32'd0);
    @(negedge clk);
    chk("lat_done", 32'(frame_done), 32'd1);
    chk("clean_data", data, 32'h1234ABCD);
    chk("clean_valid", 32'(data_valid), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(frame_done), 32'd0);
    @(negedge clk);
    chk("clean_count", 32'(fd_cnt - fd0), 32'd1);
    chk("clean_err", 32'(seq_err), 32'd0);

    // Short glitch on digit 3 must be discarded.
    w   = 32'h13579BDF;
    fd0 = fd_cnt;
    scan(w, 0, 2);
    put(3'd3, 4'hF, 2);
    scan(w, 3, 7);
    chk("glitch_count", 32'(fd_cnt - fd0), 32'd1);
    chk("glitch_data", data, 32'h13579BDF);
    chk("glitch_err", 32'(seq_err), 32'd0);

    // Skipped digit: error flag, broken frame, then recovery.
    fd0 = fd_cnt;
    put(3'd0, 4'h1, 8);
    put(3'd1, 4'h2, 8);
    an_i = 3'd3;
    d_i  = 4'h4;
    repeat (5) @(negedge clk);
    chk("err_early", 32'(seq_err), 32'd0);
    @(negedge clk);
    chk("err_set", 32'(seq_err), 32'd1);
    repeat (2) @(negedge clk);
    scan(32'h87650000, 4, 7);
    chk("err_no_frame", 32'(fd_cnt - fd0), 32'd0);
    chk("err_sticky", 32'(seq_err), 32'd1);
    chk("err_data_kept", data, 32'h13579BDF);
    scan(32'hCAFEF00D, 0, 7);
    chk("recov_count", 32'(fd_cnt - fd0), 32'd1);
    chk("recov_data", data, 32'hCAFEF00D);
    chk("recov_err", 32'(seq_err), 32'd0);

    // Value refresh with the index held.
    fd0 = fd_cnt;
    w   = 32'h76543210;
    scan(w, 0, 1);
    put(3'd2, 4'h5, 8);
    put(3'd2, 4'h9, 8);
    scan(w, 3, 7);
    chk("refresh_count", 32'(fd_cnt - fd0), 32'd1);
    chk("refresh_data", data, 32'h76543910);
    chk("refresh_err", 32'(seq_err), 32'd0);

    // Watchdog: 63 idle cycles after an accept.
    an_i = 3'd0;
    d_i  = 4'h1;
    repeat (5) @(negedge clk);
    chk("wd_idle_start", 32'(stale), 32'd0);
    repeat (63) @(negedge clk);
    chk("wd_62", 32'(stale), 32'd0);
    @(negedge clk);
    chk("wd_63", 32'(stale), 32'd1);
    repeat (5) @(negedge clk);
    chk("wd_sat", 32'(stale), 32'd1);
    an_i = 3'd1;
    d_i  = 4'h2;
    repeat (5) @(negedge clk);
    chk("wd_before_acc", 32'(stale), 32'd1);
    @(negedge clk);
    chk("wd_cleared", 32'(stale), 32'd0);

    // Asynchronous reset mid-frame clears outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_data", data, 32'h0);
    chk("arst_valid", 32'(data_valid), 32'd0);
    chk("arst_err", 32'(seq_err), 32'd0);
    chk("arst_stale", 32'(stale), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/hex_frame_capture.md
Name: hex_frame_capture

Overview:
- Receive-side counterpart of the time-multiplexed display output that scans a 32-bit word out as eight nibbles (4-bit digit value d plus 3-bit digit index an).
- Samples the multiplexed stream, filters glitches, checks scan order and reassembles the 32-bit word.
- Reports frame completion, sequencing errors and a stalled scan.
- Used to read back or loop-test any block that drives that interface, including across clock domains.

Parameters:
- STABLE_CYCLES, 4, consecutive identical synchronised {an,d} samples required before a digit is accepted; legal range 2..255.
- TIMEOUT_W, 23, width of the watchdog counter; stale asserts after 2^TIMEOUT_W-1 cycles without an accepted digit.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- d  input  4  digit value of the scanned stream; may be asynchronous to clk.
- an  input  3  digit index of the scanned stream, 0 = data[3:0] ... 7 = data[31:28]; may be asynchronous to clk.
- data  output  32  last completely captured word.
- data_valid  output  1  set by the first complete frame; stays high until reset.
- frame_done  output  1  one-cycle pulse when data updates.
- seq_err  output  1  sticky scan-order error flag.
- stale  output  1  no digit accepted for 2^TIMEOUT_W-1 cycles.

Behaviour:
- Reset (async assert, sync deassert effect):
  - All outputs 0.
  - Shadow register 0, digit mask 0, run counter 0, watchdog 0.
  - last_an = 7, so the first expected index is 0.
- Synchroniser: d and an pass through two flops (sync2) before any use.
- Stability filter:
  - prev holds the previous sync2 {an,d}.
  - If sync2 != prev, run <= 1.
  - Else run increments, saturating at STABLE_CYCLES.
  - The accept strobe fires in exactly one cycle: the cycle in which run == STABLE_CYCLES-1 and sync2 == prev.
  - No further accept occurs until {an,d} changes. Any run shorter than STABLE_CYCLES is discarded.
- On accept, with digit index a and value v:
  - shadow[4a+3:4a] <= v.
  - If a == last_an: refresh only; no order check and no mask change.
  - Else if a == last_an+1 (mod 8): mask[a] <= 1.
  - Else: seq_err <= 1, and mask <= only bit a set.
  - last_an <= a.
  - If a == 7 and the updated mask is all ones:
    - data <= updated shadow.
    - frame_done pulses for 1 cycle.
    - data_valid <= 1.
    - seq_err <= 0.
  - Whenever a == 7 (with a change of index), mask is cleared after evaluation, whether or not the frame completed.
- Latency:
  - An {an,d} change is stable at the pins before edge k and held.
  - The accept edge is k+1+STABLE_CYCLES.
  - For digit 7 completing a frame, data and frame_done update on that same edge.
- Watchdog:
  - Counter clears on accept; otherwise increments, saturating at all ones.
  - stale = (counter == all ones), registered.
  - The cycle after an accept, stale = 0.
- Simultaneous events:
  - An accept that both sets seq_err and hits a == 7 with a full mask cannot occur, since an error resets the mask.
  - A frame_done clears seq_err on the same edge.
- Reset mid-frame: partial frame and data are lost; data_valid returns to 0.
- Value change with the index held (an fixed, d changes, then stable) is accepted as a refresh. It lands in data only at the next frame completion.
- No combinational path from inputs to outputs.

Test Plan:
- Reset: assert rst_n=0 mid-operation -> all outputs 0 immediately, without a clock edge.
- Clean frame (STABLE_CYCLES=4): drive an=0..7 with the nibbles of 0x1234ABCD, each held 8 cycles -> exactly one frame_done, issued 5 edges after an=7 is applied; data=0x1234ABCD, data_valid=1, seq_err=0.
- Glitch: during the scan, insert an=3,d=F held 2 cycles between digits 2 and 3 -> no accept of F; next frame_done shows the correct digit 3.
- Order error and recovery: accept 0,1,3 -> seq_err=1 one edge after the digit-3 accept; then 4..7 -> no frame_done; then 0..7 of 0xCAFEF00D -> frame_done, data=0xCAFEF00D, seq_err=0.
- Refresh: hold an=2 and change d from 5 to 9 (stable) before the scan continues -> next frame_done carries 9 in data[11:8], seq_err stays 0.
- Watchdog (TIMEOUT_W=6): hold the inputs constant after an accept -> stale=1 after 63 idle cycles; the next accepted digit clears it on the following edge.
